// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga core memory subsystem.
// Holds the data-cache controller state encoding and line geometry.
package tartaruga_pkg;

  localparam int LINE_BITS = 128;
  localparam int WORD_BITS = 32;

  typedef enum logic [2:0] {
    DC_IDLE,
    DC_WB_REQ,
    DC_WB_WAIT,
    DC_RF_REQ,
    DC_RF_WAIT,
    DC_FILL
  } dcache_state_t;

  // Width of a selector over n items, never zero so a 1-way cache still has a legal port.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Combinational victim choice for one set: the lowest invalid way wins,
// otherwise the round-robin pointer decides.
module dcache_victim_sel
  import tartaruga_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = sel_bits(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [WAY_W-1:0]    victim_ptr,
  output logic [WAY_W-1:0]    victim_way,
  output logic                all_valid
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    victim_way = victim_ptr;
    all_valid  = &valid_vec;
    // Descending scan so the lowest-index invalid way is the last writer.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) victim_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/dcache_sa_wb.sv
// Set-associative, write-back, write-allocate data cache with a single
// outstanding miss and whole-line memory transfers.
module dcache_sa_wb
  import tartaruga_pkg::*;
#(
  parameter int NUM_SETS       = 16,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 valid_i,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [31:0]          data_wr_i,
  output logic [31:0]          data_rd_o,
  output logic                 ready_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_wr_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [LINE_BITS-1:0] mem_data_line_i,
  output logic                 mem_rsp_ready_o
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = sel_bits(NUM_WAYS);
  localparam int TAG_W = 32 - 4 - IDX_W;
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

  if ((WORDS_PER_LINE * WORD_BITS) != LINE_BITS) begin : g_line_check
    $error("dcache_sa_wb: WORDS_PER_LINE * 32 must equal LINE_BITS");
  end
  if ((NUM_SETS < 2) || ((NUM_SETS & (NUM_SETS - 1)) != 0)) begin : g_sets_check
    $error("dcache_sa_wb: NUM_SETS must be a power of two >= 2");
  end
  if ((NUM_WAYS < 1) || (NUM_WAYS > 8) || ((NUM_WAYS & (NUM_WAYS - 1)) != 0)) begin : g_ways_check
    $error("dcache_sa_wb: NUM_WAYS must be a power of two in 1..8");
  end

  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
  logic [WAY_W-1:0]     ptr_q   [NUM_SETS];
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];

  dcache_state_t state_q, state_d;
  logic [WAY_W-1:0] victim_q;
  logic [27:0]      miss_line_q;

  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic [1:0]       req_word;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             all_valid;
  logic             victim_dirty;
  logic             store_hit, start_miss, fill_now;
  logic             addr_unused;

  assign req_idx     = addr_i[4 +: IDX_W];
  assign req_tag     = addr_i[31 -: TAG_W];
  assign req_word    = addr_i[3:2];
  assign miss_idx    = miss_line_q[0 +: IDX_W];
  assign miss_tag    = miss_line_q[27 -: TAG_W];
  assign addr_unused = ^addr_i[1:0];

  assign mem_rsp_ready_o = 1'b1;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  dcache_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_victim_sel (
    .valid_vec  (valid_q[req_idx]),
    .victim_ptr (ptr_q[req_idx]),
    .victim_way (victim_way),
    .all_valid  (all_valid)
  );

  // A not-full set always yields an invalid (hence clean) victim.
  assign victim_dirty = all_valid && dirty_q[req_idx][victim_way];

  assign store_hit  = (state_q == DC_IDLE) && valid_i && we_i && hit;
  assign start_miss = (state_q == DC_IDLE) && valid_i && !hit;
  assign fill_now   = (state_q == DC_RF_WAIT) && mem_rsp_valid_i;

  always_comb begin
    state_d         = state_q;
    ready_o         = 1'b0;
    data_rd_o       = '0;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_data_wr_o   = '0;
    unique case (state_q)
      DC_IDLE: begin
        ready_o = !valid_i || hit;
        if (valid_i && hit && !we_i) begin
          data_rd_o = data_q[req_idx][hit_way][{req_word, 5'b0} +: WORD_BITS];
        end
        if (start_miss) state_d = victim_dirty ? DC_WB_REQ : DC_RF_REQ;
      end
      DC_WB_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_addr_o      = {tag_q[miss_idx][victim_q], miss_idx, 4'b0};
        mem_data_wr_o   = data_q[miss_idx][victim_q];
        if (mem_req_ready_i) state_d = DC_WB_WAIT;
      end
      DC_WB_WAIT: begin
        if (mem_rsp_valid_i) state_d = DC_RF_REQ;
      end
      DC_RF_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {miss_line_q, 4'b0};
        if (mem_req_ready_i) state_d = DC_RF_WAIT;
      end
      DC_RF_WAIT: begin
        if (mem_rsp_valid_i) state_d = DC_FILL;
      end
      DC_FILL: state_d = DC_IDLE;
      default: state_d = DC_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= DC_IDLE;
      victim_q    <= '0;
      miss_line_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        victim_q    <= victim_way;
        miss_line_q <= addr_i[31:4];
      end
      if (store_hit) dirty_q[req_idx][hit_way] <= 1'b1;
      if (fill_now) begin
        valid_q[miss_idx][victim_q] <= 1'b1;
        dirty_q[miss_idx][victim_q] <= 1'b0;
        ptr_q[miss_idx] <= (ptr_q[miss_idx] == LAST_WAY) ? '0 : ptr_q[miss_idx] + 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the cleared valid bits make their contents unobservable.
  always_ff @(posedge clk_i) begin
    if (rstn_i && store_hit) begin
      data_q[req_idx][hit_way][{req_word, 5'b0} +: WORD_BITS] <= data_wr_i;
    end
    if (rstn_i && fill_now) begin
      tag_q[miss_idx][victim_q]  <= miss_tag;
      data_q[miss_idx][victim_q] <= mem_data_line_i;
    end
  end

endmodule

// File: tb/tb_dcache_sa_wb.sv
// Directed bench for dcache_sa_wb: a line-memory responder checks each
// memory request against a queue of expected transactions.
module tb_dcache_sa_wb;

  logic         clk_i = 1'b0;
  logic         rstn_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [31:0]  addr_i = '0;
  logic         we_i = 1'b0;
  logic [31:0]  data_wr_i = '0;
  logic [31:0]  data_rd_o;
  logic         ready_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i = 1'b0;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_wr_o;
  logic         mem_rsp_valid_i = 1'b0;
  logic [127:0] mem_data_line_i = '0;
  logic         mem_rsp_ready_o;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
  } mem_exp_t;

  mem_exp_t     mem_exp_q[$];
  logic [31:0]  rd_exp_q[$];
  logic [127:0] mem_model [logic [31:0]];

  int checks = 0;
  int failures = 0;
  bit mem_auto = 1'b0;
  bit seen = 1'b0;
  int stall_left = 0;
  int stall_next = 0;
  logic         cur_we = 1'b0;
  logic [31:0]  cur_addr = '0;
  logic [127:0] cur_data = '0;

  dcache_sa_wb #(
    .NUM_SETS       (16),
    .NUM_WAYS       (2),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .valid_i         (valid_i),
    .addr_i          (addr_i),
    .we_i            (we_i),
    .data_wr_i       (data_wr_i),
    .data_rd_o       (data_rd_o),
    .ready_o         (ready_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_we_o        (mem_we_o),
    .mem_addr_o      (mem_addr_o),
    .mem_data_wr_o   (mem_data_wr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_data_line_i (mem_data_line_i),
    .mem_rsp_ready_o (mem_rsp_ready_o)
  );

  initial forever #5 clk_i = ~clk_i;

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'hC0DE_0003, a ^ 32'hC0DE_0002, a ^ 32'hC0DE_0001, a ^ 32'hC0DE_0000};
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] l, input int w);
    return l[w*32 +: 32];
  endfunction

  function automatic logic [127:0] line_for(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return pat(a);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [127:0] d);
    mem_exp_t e;
    e.we = we;
    e.addr = a;
    e.data = d;
    mem_exp_q.push_back(e);
  endtask

  // Memory responder, run once per falling edge: accept after the programmed
  // stall, answer in the cycle after acceptance.
  task automatic mem_service();
    mem_exp_t e;
    mem_rsp_valid_i = 1'b0;
    if (mem_req_ready_i) begin
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1;
      seen = 1'b0;
      if (cur_we) begin
        mem_model[cur_addr] = cur_data;
        mem_data_line_i = '0;
      end else begin
        mem_data_line_i = line_for(cur_addr);
      end
    end else if (mem_req_valid_o) begin
      if (!seen) begin
        seen = 1'b1;
        stall_left = stall_next;
        stall_next = 0;
        if (mem_exp_q.size() == 0) begin
          check("mem_req_expected", 128'(mem_exp_q.size()), 128'(1));
          cur_we = mem_we_o;
          cur_addr = mem_addr_o;
          cur_data = mem_data_wr_o;
        end else begin
          e = mem_exp_q.pop_front();
          check("mem_req_we", 128'(mem_we_o), 128'(e.we));
          check("mem_req_addr", 128'(mem_addr_o), 128'(e.addr));
          if (e.we) check("mem_req_wb_data", mem_data_wr_o, e.data);
          cur_we = e.we;
          cur_addr = e.addr;
          cur_data = e.data;
        end
      end else begin
        check("stall_addr_stable", 128'(mem_addr_o), 128'(cur_addr));
        check("stall_we_stable", 128'(mem_we_o), 128'(cur_we));
        if (cur_we) check("stall_data_stable", mem_data_wr_o, cur_data);
        check("stall_ready_low", 128'(ready_o), 128'(0));
      end
      if (stall_left == 0) mem_req_ready_i = 1'b1;
      else stall_left--;
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    if (mem_auto) mem_service();
  endtask

  // One core request; exp_lat is the falling-edge count until ready_o.
  task automatic access(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat);
    bit done;
    int lat;
    step();
    addr_i = a;
    we_i = w;
    data_wr_i = d;
    valid_i = 1'b1;
    if (!w) rd_exp_q.push_back(exp_rd);
    done = 1'b0;
    lat = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (ready_o) begin
        done = 1'b1;
        lat = c;
        if (c == 0) check({tag, "_no_mem_traffic"}, 128'(mem_req_valid_o), 128'(0));
        if (!w) check({tag, "_rd_data"}, 128'(data_rd_o), 128'(rd_exp_q.pop_front()));
      end else begin
        step();
      end
    end
    check({tag, "_completed"}, 128'(done), 128'(1));
    if (done) check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    step();
    valid_i = 1'b0;
  endtask

  task automatic do_reset(input bit probe);
    mem_auto = 1'b0;
    rstn_i = 1'b0;
    valid_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    seen = 1'b0;
    stall_next = 0;
    mem_exp_q.delete();
    rd_exp_q.delete();
    for (int i = 0; i < 3; i++) step();
    if (probe) begin
      addr_i = 32'h0000_0040;
      valid_i = 1'b1;
      #1;
      check("rst_ready_with_valid", 128'(ready_o), 128'(0));
      step();
      valid_i = 1'b0;
      #1;
      check("rst_ready_idle", 128'(ready_o), 128'(1));
      check("rst_mem_req_valid", 128'(mem_req_valid_o), 128'(0));
      check("rst_mem_we", 128'(mem_we_o), 128'(0));
      check("rst_mem_addr", 128'(mem_addr_o), 128'(0));
      check("rst_mem_data_wr", mem_data_wr_o, 128'(0));
      check("rst_data_rd", 128'(data_rd_o), 128'(0));
      check("rst_mem_rsp_ready", 128'(mem_rsp_ready_o), 128'(1));
    end
    step();
    rstn_i = 1'b1;
    mem_auto = 1'b1;
  endtask

  initial begin
    logic [127:0] exp_wb;
    logic [127:0] exp_wb2;

    mem_model[32'h0000_0100] = {32'h44, 32'h33, 32'h22, 32'h11};
    do_reset(1'b1);

    // Cold load, then store hit and read-back on the resident line.
    push_req(1'b0, 32'h0000_0100, '0);
    access("cold_ld", 32'h0000_0104, 1'b0, '0, 32'h22, 4);
    access("st_hit", 32'h0000_0104, 1'b1, 32'hDEAD_BEEF, '0, 0);
    access("ld_after_st", 32'h0000_0104, 1'b0, '0, 32'hDEAD_BEEF, 0);

    // Round-robin replacement in set 0.
    do_reset(1'b0);
    push_req(1'b0, 32'h0000_0000, '0);
    access("fill_0000", 32'h0000_0000, 1'b0, '0, word_of(pat(32'h0), 0), 4);
    push_req(1'b0, 32'h0000_0100, '0);
    access("fill_0100", 32'h0000_0100, 1'b0, '0, 32'h11, 4);
    push_req(1'b0, 32'h0000_0200, '0);
    access("fill_0200", 32'h0000_0200, 1'b0, '0, word_of(pat(32'h200), 0), 4);
    access("hit_0100", 32'h0000_0104, 1'b0, '0, 32'h22, 0);
    push_req(1'b0, 32'h0000_0000, '0);
    access("evicted_0000", 32'h0000_0000, 1'b0, '0, word_of(pat(32'h0), 0), 4);

    // Dirty eviction: writeback strictly before refill.
    do_reset(1'b0);
    push_req(1'b0, 32'h0000_0000, '0);
    access("st_miss", 32'h0000_0008, 1'b1, 32'h1122_3344, '0, 4);
    push_req(1'b0, 32'h0000_0100, '0);
    access("fill_way1", 32'h0000_0100, 1'b0, '0, 32'h11, 4);
    exp_wb = pat(32'h0);
    exp_wb[95:64] = 32'h1122_3344;
    push_req(1'b1, 32'h0000_0000, exp_wb);
    push_req(1'b0, 32'h0000_0200, '0);
    access("dirty_evict", 32'h0000_0204, 1'b0, '0, word_of(pat(32'h200), 1), 6);
    push_req(1'b0, 32'h0000_0000, '0);
    access("wb_roundtrip", 32'h0000_0008, 1'b0, '0, 32'h1122_3344, 4);

    // Writeback held off for 5 cycles.
    do_reset(1'b0);
    push_req(1'b0, 32'h0000_0000, '0);
    access("st_miss2", 32'h0000_0000, 1'b1, 32'hCAFE_F00D, '0, 4);
    push_req(1'b0, 32'h0000_0100, '0);
    access("fill_way1b", 32'h0000_0100, 1'b0, '0, 32'h11, 4);
    exp_wb2 = exp_wb;
    exp_wb2[31:0] = 32'hCAFE_F00D;
    push_req(1'b1, 32'h0000_0000, exp_wb2);
    push_req(1'b0, 32'h0000_0200, '0);
    stall_next = 5;
    access("wb_stall", 32'h0000_0200, 1'b0, '0, word_of(pat(32'h200), 0), 11);

    // Reset during RF_WAIT with a late response afterwards.
    do_reset(1'b0);
    mem_auto = 1'b0;
    step();
    addr_i = 32'h0000_0300;
    we_i = 1'b0;
    valid_i = 1'b1;
    step();
    #1;
    check("abort_req_valid", 128'(mem_req_valid_o), 128'(1));
    check("abort_req_addr", 128'(mem_addr_o), 128'(32'h0000_0300));
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    #1;
    check("abort_wait_ready", 128'(ready_o), 128'(0));
    rstn_i = 1'b0;
    valid_i = 1'b0;
    step();
    rstn_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_data_line_i = {4{32'hFFFF_FFFF}};
    step();
    mem_rsp_valid_i = 1'b0;
    #1;
    check("abort_idle_ready", 128'(ready_o), 128'(1));
    check("abort_no_req", 128'(mem_req_valid_o), 128'(0));
    seen = 1'b0;
    mem_auto = 1'b1;
    push_req(1'b0, 32'h0000_0300, '0);
    access("after_abort", 32'h0000_0300, 1'b0, '0, word_of(pat(32'h300), 0), 4);

    check("mem_queue_drained", 128'(mem_exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
